grad_abs_pipe: RTL and testbench

GRAD_ABS_PIPE -- requirements
Module: grad_abs_pipe

---
 rtl/cfa_pkg.sv | 22 ++
 rtl/grad_abs_pipe_abs_diff.sv | 18 +
 rtl/grad_abs_pipe.sv | 123 ++++++++++++
 tb/tb_grad_abs_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cfa_pkg.sv
// Shared constants for the gradient-magnitude pipeline: default pixel width,
// mode encodings, per-tap weight shifts and the minimum output width rule.
package cfa_pkg;

    localparam int PIXEL_W_DEFAULT = 12;
    localparam int NUM_TAPS        = 5;

    typedef enum logic {
        MODE_WEIGHTED = 1'b0,   // weights 1,2,4,2,1
        MODE_UNIFORM  = 1'b1    // weights 1,1,1,1,1
    } mode_e;

    // Weights are powers of two, applied as left shifts per tap e1..e5.
    localparam int TAP_SHIFT [NUM_TAPS] = '{0, 1, 2, 1, 0};

    // Worst case is ten times the largest difference (weights sum to 10),
    // which needs four extra bits above the pixel width.
    function automatic int min_out_w(input int pixel_w);
        return pixel_w + 4;
    endfunction

endpackage

// File: rtl/grad_abs_pipe_abs_diff.sv
// Exact |a - b| for unsigned pixels, purely combinational.
module abs_diff #(
    parameter int PIXEL_W = 12
) (
    input  logic [PIXEL_W-1:0] a,
    input  logic [PIXEL_W-1:0] b,
    output logic [PIXEL_W-1:0] y
);

    logic signed [PIXEL_W:0] diff;

    // Signed difference one bit wider than the pixels, folded to its magnitude.
    always_comb begin
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        y    = diff[PIXEL_W] ? PIXEL_W'(-diff) : diff[PIXEL_W-1:0];
    end

endmodule

// File: rtl/grad_abs_pipe.sv
// Three-stage weighted sum of absolute differences between a local mean and
// five neighbour pixels, with valid/ready flow control on both sides.
module grad_abs_pipe
    import cfa_pkg::*;
#(
    parameter int PIXEL_W = PIXEL_W_DEFAULT,
    parameter int OUT_W   = PIXEL_W + 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIXEL_W-1:0] e1,
    input  logic [PIXEL_W-1:0] e2,
    input  logic [PIXEL_W-1:0] e3,
    input  logic [PIXEL_W-1:0] e4,
    input  logic [PIXEL_W-1:0] e5,
    input  logic [PIXEL_W-1:0] mean_1,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [OUT_W-1:0]   grad_abs,
    output logic               out_valid,
    input  logic               out_ready
);

    generate
        if (OUT_W < min_out_w(PIXEL_W)) begin : g_out_w_too_small
            $error("grad_abs_pipe: OUT_W must be at least PIXEL_W+4");
        end
    endgenerate

    // ---------------- stage valids and load conditions ----------------
    logic v1, v2, v3;
    logic ld1, ld2, ld3;

    // A stage loads when it is empty or its contents leave this cycle.
    // NOTE: ld chain is combinational from out_ready back to in_ready; that
    // is what allows full throughput without a skid buffer.
    assign ld3      = !v3 || out_ready;
    assign ld2      = !v2 || ld3;
    assign ld1      = !v1 || ld2;
    assign in_ready = ld1 && !rst;

    // Stage valid bits advance with their load conditions; reset empties all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (ld1) v1 <= in_valid;
            if (ld2) v2 <= v1;
            if (ld3) v3 <= v2;
        end
    end

    // ---------------- S1: absolute differences ----------------
    logic [PIXEL_W-1:0] pix   [NUM_TAPS];
    logic [PIXEL_W-1:0] abs_c [NUM_TAPS];

    assign pix[0] = e1;
    assign pix[1] = e2;
    assign pix[2] = e3;
    assign pix[3] = e4;
    assign pix[4] = e5;

    for (genvar i = 0; i < NUM_TAPS; i++) begin : g_abs
        abs_diff #(.PIXEL_W(PIXEL_W)) u_abs_diff (
            .a (mean_1),
            .b (pix[i]),
            .y (abs_c[i])
        );
    end

    logic [PIXEL_W-1:0] s1_abs [NUM_TAPS];
    mode_e              s1_mode;

    // ---------------- S2: weighting and partial sums ----------------
    logic [OUT_W-1:0] w_c [NUM_TAPS];

    // Zero-extend each difference, then shift by its tap weight in weighted mode.
    always_comb begin
        for (int i = 0; i < NUM_TAPS; i++) begin
            w_c[i] = OUT_W'(s1_abs[i]);
            if (s1_mode == MODE_WEIGHTED) begin
                w_c[i] = w_c[i] << TAP_SHIFT[i];
            end
        end
    end

    logic [OUT_W-1:0] s2_p0, s2_p1, s2_p2;

    // Data registers of S1/S2 follow their stage's load; contents of an empty
    // stage are don't-care.
    // NOTE: these payload registers have no reset on purpose -- the valid bits
    // alone decide whether they mean anything, so resetting them buys nothing.
    always_ff @(posedge clk) begin
        if (ld1 && in_valid) begin
            s1_abs  <= abs_c;
            s1_mode <= mode_e'(mode);
        end
        if (ld2 && v1) begin
            s2_p0 <= w_c[0] + w_c[1];
            s2_p1 <= w_c[2] + w_c[3];
            s2_p2 <= w_c[4];
        end
    end

    // ---------------- S3: final sum ----------------
    logic [OUT_W-1:0] s3_sum;

    // Output register is reset so grad_abs reads 0 until the first result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_sum <= '0;
        end else if (ld3 && v2) begin
            s3_sum <= s2_p0 + s2_p1 + s2_p2;
        end
    end

    assign grad_abs  = s3_sum;
    assign out_valid = v3;

endmodule

// File: tb/tb_grad_abs_pipe.sv
// Self-checking bench for grad_abs_pipe: a scoreboard of results computed
// from plain arithmetic, checked at every output handover, plus directed
// literal cases, backpressure, alternating mode and mid-stream reset.
module tb_grad_abs_pipe;

    localparam int PW = 12;
    localparam int OW = PW + 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] e1, e2, e3, e4, e5, mean_1;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] grad_abs;
    logic          out_valid;
    logic          out_ready;

    grad_abs_pipe #(.PIXEL_W(PW), .OUT_W(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .e1        (e1),
        .e2        (e2),
        .e3        (e3),
        .e4        (e4),
        .e5        (e5),
        .mean_1    (mean_1),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .grad_abs  (grad_abs),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: sum of weight * |mean - e| with ordinary integer arithmetic.
    function automatic int unsigned model(input int unsigned m, input int unsigned ev [5], input bit md);
        int unsigned wt [5];
        int unsigned s;
        int d;
        wt = '{1, 2, 4, 2, 1};
        s  = 0;
        for (int i = 0; i < 5; i++) begin
            d = int'(m) - int'(ev[i]);
            if (d < 0) d = -d;
            s += (md ? 1 : wt[i]) * int'(d);
        end
        return s;
    endfunction

    function automatic logic [PW-1:0] rand_pix();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            default: return PW'($urandom_range(0, (1 << PW) - 1));
        endcase
    endfunction

    // ---------------- scoreboard and monitor ----------------
    typedef struct {
        int unsigned val;
        int          xfer_edge;
        bit          stalled;
    } exp_t;

    exp_t          sb_q [$];
    int            edge_cnt   = 0;
    int            n_xfer     = 0;
    int            n_out      = 0;
    bit            prev_stall = 1'b0;
    logic [OW-1:0] prev_data  = '0;
    bit            seen_valid = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Sampled mid-cycle: everything seen here acts on the next rising edge.
    always @(negedge clk) begin
        int unsigned ev [5];
        exp_t        ent;
        if (rst) begin
            sb_q.delete();
            prev_stall = 1'b0;
            seen_valid = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", out_valid, 1);
                check("stall_hold_data", grad_abs, prev_data);
            end
            if (!seen_valid && !out_valid) check("idle_zero", grad_abs, 0);
            if (out_valid) seen_valid = 1'b1;
            if (out_ready) check("ready_full_rate", in_ready, 1);

            if (out_valid && out_ready) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    check("unexpected_output", out_valid, 0);
                end else begin
                    ent = sb_q.pop_front();
                    check("result", grad_abs, ent.val);
                    if (!ent.stalled) check("latency", edge_cnt + 1 - ent.xfer_edge, 3);
                end
            end

            if (in_valid && in_ready) begin
                ev = '{e1, e2, e3, e4, e5};
                ent.val       = model(mean_1, ev, mode);
                ent.xfer_edge = edge_cnt + 1;
                ent.stalled   = 1'b0;
                sb_q.push_back(ent);
                n_xfer++;
            end

            if (!out_ready) begin
                foreach (sb_q[i]) sb_q[i].stalled = 1'b1;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = grad_abs;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_sample(input int m, input int a, input int b, input int c,
                              input int d, input int e, input bit md);
        mean_1 = PW'(m);
        e1 = PW'(a); e2 = PW'(b); e3 = PW'(c); e4 = PW'(d); e5 = PW'(e);
        mode = md;
    endtask

    task automatic set_random(input bit md);
        mean_1 = rand_pix();
        e1 = rand_pix(); e2 = rand_pix(); e3 = rand_pix(); e4 = rand_pix(); e5 = rand_pix();
        mode = md;
    endtask

    // Called mid-cycle with an empty pipeline and out_ready high: one transfer
    // on the next edge, result must be on the output after the second edge
    // following it and handed over on the third.
    task automatic directed(input string nm, input int m, input int a, input int b,
                            input int c, input int d, input int e, input bit md,
                            input int unsigned lit);
        int unsigned ev [5];
        ev = '{a, b, c, d, e};
        check({nm, "_model"}, model(m, ev, md), lit);
        set_sample(m, a, b, c, d, e, md);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 check({nm, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk); check({nm, "_early0"}, out_valid, 0);
        @(negedge clk); check({nm, "_early1"}, out_valid, 0);
        @(negedge clk);
        check({nm, "_valid"}, out_valid, 1);
        check({nm, "_value"}, grad_abs, lit);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int x0, o0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_sample(0, 0, 0, 0, 0, 0, 1'b0);
        #3;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_grad_abs", grad_abs, 0);
        @(posedge clk); @(posedge clk); #3 rst = 1'b0;

        // Directed literal cases.
        directed("weighted",  100,   90,  110,  100,   95,  105, 1'b0, 45);
        directed("uniform",   100,   90,  110,  100,   95,  105, 1'b1, 30);
        directed("max_w",    4095,    0,    0,    0,    0,    0, 1'b0, 40950);
        directed("max_u",    4095,    0,    0,    0,    0,    0, 1'b1, 20475);
        directed("neg_w",       0, 4095, 4095, 4095, 4095, 4095, 1'b0, 40950);
        drain();

        // Mode alternating every cycle at full throughput.
        for (int i = 0; i < 24; i++) begin
            set_random(i[0]);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        drain();

        // Backpressure: output blocked, input offered for six cycles.
        x0 = n_xfer; o0 = n_out;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_random(i[0]);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        check("bp_accepted", n_xfer - x0, 3);
        check("bp_in_ready", in_ready, 0);
        drain();
        check("bp_outputs", n_out - o0, 3);
        check("bp_queue", sb_q.size(), 0);

        // Randomized traffic on both sides.
        for (int i = 0; i < 400; i++) begin
            set_random(1'($urandom_range(0, 1)));
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        drain();
        check("rand_queue", sb_q.size(), 0);

        // Reset with two samples in flight.
        set_random(1'b0); in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 set_random(1'b1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_pre_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_grad_abs", grad_abs, 0);
        check("mid_rst_in_ready", in_ready, 0);
        @(posedge clk); @(posedge clk); #3 rst = 1'b0;
        directed("post_rst", 100, 90, 110, 100, 95, 105, 1'b0, 45);
        drain();
        check("final_queue", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
